// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, 16-bit ALU with condition codes, EX/MEM
// pipeline register and the three-slot interrupt push sequencer.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  Rsrc_address,
    input  logic [2:0]  Rdst_address,
    input  logic [15:0] Rsrc_value,
    input  logic [15:0] Rdst_value,
    input  logic [15:0] imm,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        WB,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] pc,
    input  logic [15:0] MEMWB_data,
    input  logic [2:0]  MEMWB_Rdst_address,
    input  logic        MEMWB_WB,
    input  logic        stall,
    input  logic        flush,
    input  logic        int_req,
    output logic [15:0] EXMEM_ALU_result,
    output logic [15:0] EXMEM_Rsrc_value,
    output logic [15:0] EXMEM_Rdst_value,
    output logic [2:0]  EXMEM_Rdst_address,
    output logic        EXMEM_memRead,
    output logic        EXMEM_memWrite,
    output logic        EXMEM_WB,
    output logic        EXMEM_push,
    output logic        EXMEM_pop,
    output logic [31:0] EXMEM_pc,
    output logic [1:0]  intCounterValue,
    output logic        intSignalFromCounter,
    output logic [15:0] flagReg,
    output logic        int_busy
);

    // State encoding doubles as the memory-stage write-data select value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PC_HI = 2'b01,
        S_PC_LO = 2'b10,
        S_FLAGS = 2'b11
    } int_state_t;

    int_state_t  r_state;
    logic [31:0] r_ra;

    logic        w_exmem_fwd_ok;
    logic [15:0] w_s;
    logic [15:0] w_d;
    logic [15:0] w_result;
    logic [16:0] w_wide;
    logic [3:0]  w_shamt;
    logic        w_zn_upd;
    logic        w_c;
    logic        w_z;
    logic        w_n;
    logic [15:0] w_flags_next;

    assign int_busy = (r_state != S_IDLE);

    // A load in EX/MEM has no data yet; that case is stalled by the hazard unit.
    assign w_exmem_fwd_ok = EXMEM_WB && !EXMEM_memRead;

    always_comb begin
        if (w_exmem_fwd_ok && (EXMEM_Rdst_address == Rsrc_address))
            w_s = EXMEM_ALU_result;
        else if (MEMWB_WB && (MEMWB_Rdst_address == Rsrc_address))
            w_s = MEMWB_data;
        else
            w_s = Rsrc_value;

        if (w_exmem_fwd_ok && (EXMEM_Rdst_address == Rdst_address))
            w_d = EXMEM_ALU_result;
        else if (MEMWB_WB && (MEMWB_Rdst_address == Rdst_address))
            w_d = MEMWB_data;
        else
            w_d = Rdst_value;
    end

    assign w_shamt = imm[3:0];

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_result = w_d;
        w_wide   = 17'd0;
        w_zn_upd = 1'b0;
        w_c      = flagReg[2];
        case (alu_op)
            4'h1: begin
                w_result = ~w_d;
                w_zn_upd = 1'b1;
            end
            4'h2: begin
                w_wide   = {1'b0, w_d} + 17'd1;
                w_result = w_wide[15:0];
                w_c      = w_wide[16];
                w_zn_upd = 1'b1;
            end
            4'h3: begin
                w_wide   = {1'b0, w_d} - 17'd1;
                w_result = w_wide[15:0];
                w_c      = w_wide[16];
                w_zn_upd = 1'b1;
            end
            4'h4: begin
                w_wide   = {1'b0, w_d} + {1'b0, w_s};
                w_result = w_wide[15:0];
                w_c      = w_wide[16];
                w_zn_upd = 1'b1;
            end
            4'h5: begin
                w_wide   = {1'b0, w_d} - {1'b0, w_s};
                w_result = w_wide[15:0];
                w_c      = w_wide[16];
                w_zn_upd = 1'b1;
            end
            4'h6: begin
                w_result = w_d & w_s;
                w_zn_upd = 1'b1;
            end
            4'h7: begin
                w_result = w_d | w_s;
                w_zn_upd = 1'b1;
            end
            4'h8: begin
                // Bit 16 of the widened shift is the last bit shifted out.
                w_wide   = {1'b0, w_d} << w_shamt;
                w_result = w_wide[15:0];
                if (w_shamt != 4'd0)
                    w_c = w_wide[16];
                w_zn_upd = 1'b1;
            end
            4'h9: begin
                w_wide   = {w_d, 1'b0} >> w_shamt;
                w_result = w_wide[16:1];
                if (w_shamt != 4'd0)
                    w_c = w_wide[0];
                w_zn_upd = 1'b1;
            end
            4'hA:    w_c = 1'b1;
            4'hB:    w_c = 1'b0;
            4'hC:    w_result = w_s;
            4'hD:    w_result = imm;
            default: w_result = w_d;
        endcase
    end

    assign w_z          = w_zn_upd ? (w_result == 16'd0) : flagReg[0];
    assign w_n          = w_zn_upd ? w_result[15] : flagReg[1];
    assign w_flags_next = {13'd0, w_c, w_n, w_z};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            EXMEM_ALU_result     <= '0;
            EXMEM_Rsrc_value     <= '0;
            EXMEM_Rdst_value     <= '0;
            EXMEM_Rdst_address   <= '0;
            EXMEM_memRead        <= 1'b0;
            EXMEM_memWrite       <= 1'b0;
            EXMEM_WB             <= 1'b0;
            EXMEM_push           <= 1'b0;
            EXMEM_pop            <= 1'b0;
            EXMEM_pc             <= '0;
            intCounterValue      <= 2'b00;
            intSignalFromCounter <= 1'b0;
            flagReg              <= '0;
            r_state              <= S_IDLE;
            r_ra                 <= '0;
        end else if (r_state != S_IDLE) begin
            // Push slot: data fields are left alone, the memory stage picks
            // the write data from intCounterValue.
            EXMEM_memRead        <= 1'b0;
            EXMEM_memWrite       <= 1'b1;
            EXMEM_WB             <= 1'b0;
            EXMEM_push           <= 1'b1;
            EXMEM_pop            <= 1'b0;
            EXMEM_pc             <= r_ra;
            intCounterValue      <= r_state;
            intSignalFromCounter <= 1'b1;
            case (r_state)
                S_PC_HI: r_state <= S_PC_LO;
                S_PC_LO: r_state <= S_FLAGS;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            intCounterValue      <= 2'b00;
            intSignalFromCounter <= 1'b0;
            if (int_req) begin
                r_state <= S_PC_HI;
                r_ra    <= pc + 32'd1;
            end
            if (!stall) begin
                EXMEM_ALU_result   <= w_result;
                EXMEM_Rsrc_value   <= w_s;
                EXMEM_Rdst_value   <= w_d;
                EXMEM_Rdst_address <= Rdst_address;
                EXMEM_pc           <= pc;
                if (flush) begin
                    EXMEM_memRead  <= 1'b0;
                    EXMEM_memWrite <= 1'b0;
                    EXMEM_WB       <= 1'b0;
                    EXMEM_push     <= 1'b0;
                    EXMEM_pop      <= 1'b0;
                end else begin
                    EXMEM_memRead  <= memRead;
                    EXMEM_memWrite <= memWrite;
                    EXMEM_WB       <= WB;
                    EXMEM_push     <= push;
                    EXMEM_pop      <= pop;
                    flagReg        <= w_flags_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver queues the expected EX/MEM
// state for each edge, the monitor compares it on the following falling edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic [2:0]  Rsrc_address, Rdst_address;
    logic [15:0] Rsrc_value, Rdst_value, imm;
    logic        memRead, memWrite, WB, push, pop;
    logic [31:0] pc;
    logic [15:0] MEMWB_data;
    logic [2:0]  MEMWB_Rdst_address;
    logic        MEMWB_WB, stall, flush, int_req;
    logic [15:0] EXMEM_ALU_result, EXMEM_Rsrc_value, EXMEM_Rdst_value;
    logic [2:0]  EXMEM_Rdst_address;
    logic        EXMEM_memRead, EXMEM_memWrite, EXMEM_WB, EXMEM_push, EXMEM_pop;
    logic [31:0] EXMEM_pc;
    logic [1:0]  intCounterValue;
    logic        intSignalFromCounter;
    logic [15:0] flagReg;
    logic        int_busy;

    execute_stage dut (
        .clk(clk), .rst(rst), .alu_op(alu_op),
        .Rsrc_address(Rsrc_address), .Rdst_address(Rdst_address),
        .Rsrc_value(Rsrc_value), .Rdst_value(Rdst_value), .imm(imm),
        .memRead(memRead), .memWrite(memWrite), .WB(WB), .push(push), .pop(pop),
        .pc(pc), .MEMWB_data(MEMWB_data), .MEMWB_Rdst_address(MEMWB_Rdst_address),
        .MEMWB_WB(MEMWB_WB), .stall(stall), .flush(flush), .int_req(int_req),
        .EXMEM_ALU_result(EXMEM_ALU_result), .EXMEM_Rsrc_value(EXMEM_Rsrc_value),
        .EXMEM_Rdst_value(EXMEM_Rdst_value), .EXMEM_Rdst_address(EXMEM_Rdst_address),
        .EXMEM_memRead(EXMEM_memRead), .EXMEM_memWrite(EXMEM_memWrite),
        .EXMEM_WB(EXMEM_WB), .EXMEM_push(EXMEM_push), .EXMEM_pop(EXMEM_pop),
        .EXMEM_pc(EXMEM_pc), .intCounterValue(intCounterValue),
        .intSignalFromCounter(intSignalFromCounter), .flagReg(flagReg),
        .int_busy(int_busy)
    );

    always #5 clk = ~clk;

    // Control bit order: {memRead, memWrite, WB, push, pop}
    localparam logic [4:0] C_RD   = 5'b10000;
    localparam logic [4:0] C_MW   = 5'b01000;
    localparam logic [4:0] C_WB   = 5'b00100;
    localparam logic [4:0] C_PU   = 5'b00010;
    localparam logic [4:0] C_PO   = 5'b00001;
    localparam logic [4:0] C_SLOT = 5'b01010;

    typedef struct {
        int          cyc;
        string       name;
        logic        chk_data;
        logic [15:0] res, rs, rd;
        logic [2:0]  ra;
        logic [4:0]  ctl;
        logic [31:0] pcv;
        logic [1:0]  icv;
        logic        isig;
        logic [15:0] flags;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0; MEMWB_WB = 1'b0; MEMWB_Rdst_address = 3'd0; MEMWB_data = 16'd0;
        stall = 1'b0; flush = 1'b0; int_req = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] sa, input logic [15:0] sv,
                         input logic [2:0] da, input logic [15:0] dv, input logic [15:0] im,
                         input logic [4:0] ctl, input logic [31:0] p);
        alu_op = op; Rsrc_address = sa; Rsrc_value = sv;
        Rdst_address = da; Rdst_value = dv; imm = im; pc = p;
        {memRead, memWrite, WB, push, pop} = ctl;
    endtask

    task automatic expect_v(input string nm, input logic chk, input logic [15:0] res,
                            input logic [15:0] rs, input logic [15:0] rd, input logic [2:0] ra,
                            input logic [4:0] ctl, input logic [31:0] p, input logic [1:0] icv,
                            input logic isig, input logic [15:0] flags, input logic busy);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.chk_data = chk;
        e.res = res; e.rs = rs; e.rd = rd; e.ra = ra; e.ctl = ctl; e.pcv = p;
        e.icv = icv; e.isig = isig; e.flags = flags; e.busy = busy;
        q.push_back(e);
    endtask

    // Monitor: pops every entry due at this cycle and compares it.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [4:0] act_ctl;
                logic       ok;
                e = q.pop_front();
                act_ctl = {EXMEM_memRead, EXMEM_memWrite, EXMEM_WB, EXMEM_push, EXMEM_pop};
                ok = (act_ctl === e.ctl) && (EXMEM_pc === e.pcv) &&
                     (intCounterValue === e.icv) && (intSignalFromCounter === e.isig) &&
                     (flagReg === e.flags) && (int_busy === e.busy);
                if (e.chk_data)
                    ok = ok && (EXMEM_ALU_result === e.res) && (EXMEM_Rsrc_value === e.rs) &&
                         (EXMEM_Rdst_value === e.rd) && (EXMEM_Rdst_address === e.ra);
                n_vec++;
                if (!ok) begin
                    n_miss++;
                    $display("FAIL %s: got res=%h rs=%h rd=%h ra=%0d ctl=%b pc=%h icv=%b isig=%b flags=%h busy=%b; want res=%h rs=%h rd=%h ra=%0d ctl=%b pc=%h icv=%b isig=%b flags=%h busy=%b (data checked=%b)",
                             e.name, EXMEM_ALU_result, EXMEM_Rsrc_value, EXMEM_Rdst_value,
                             EXMEM_Rdst_address, act_ctl, EXMEM_pc, intCounterValue,
                             intSignalFromCounter, flagReg, int_busy,
                             e.res, e.rs, e.rd, e.ra, e.ctl, e.pcv, e.icv, e.isig,
                             e.flags, e.busy, e.chk_data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; MEMWB_WB = 1'b0; MEMWB_Rdst_address = 3'd0; MEMWB_data = 16'd0;
        stall = 1'b0; flush = 1'b0; int_req = 1'b0;
        drive(4'h0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0, 5'b0, 32'h0);

        next_cycle(); rst = 1'b1;
        drive(4'h0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0, 5'b0, 32'h0);
        expect_v("reset", 1, 16'h0, 16'h0, 16'h0, 3'd0, 5'b0, 32'h0, 2'b00, 0, 16'h0, 0);

        next_cycle(); drive(4'h4, 3'd1, 16'h0001, 3'd2, 16'hFFFF, 16'h0, C_WB, 32'h10);
        expect_v("add_wrap", 1, 16'h0000, 16'h0001, 16'hFFFF, 3'd2, C_WB, 32'h10, 2'b00, 0, 16'h0005, 0);

        next_cycle(); drive(4'h4, 3'd0, 16'h0004, 3'd1, 16'h000C, 16'h0, C_WB, 32'h11);
        expect_v("add_r1", 1, 16'h0010, 16'h0004, 16'h000C, 3'd1, C_WB, 32'h11, 2'b00, 0, 16'h0000, 0);

        next_cycle(); MEMWB_WB = 1; MEMWB_Rdst_address = 3'd1; MEMWB_data = 16'h0020;
        drive(4'h5, 3'd1, 16'h1111, 3'd2, 16'h0030, 16'h0, C_WB, 32'h12);
        expect_v("fwd_exmem_prio", 1, 16'h0020, 16'h0010, 16'h0030, 3'd2, C_WB, 32'h12, 2'b00, 0, 16'h0000, 0);

        next_cycle(); drive(4'h0, 3'd4, 16'h0200, 3'd3, 16'h0100, 16'h0, C_RD | C_WB, 32'h13);
        expect_v("load_r3", 1, 16'h0100, 16'h0200, 16'h0100, 3'd3, C_RD | C_WB, 32'h13, 2'b00, 0, 16'h0000, 0);

        next_cycle(); MEMWB_WB = 1; MEMWB_Rdst_address = 3'd3; MEMWB_data = 16'h0007;
        drive(4'h4, 3'd5, 16'h0001, 3'd3, 16'h9999, 16'h0, C_WB, 32'h14);
        expect_v("fwd_memwb_load", 1, 16'h0008, 16'h0001, 16'h0007, 3'd3, C_WB, 32'h14, 2'b00, 0, 16'h0000, 0);

        next_cycle(); drive(4'h5, 3'd7, 16'h0005, 3'd0, 16'h0003, 16'h0, 5'b0, 32'h15);
        expect_v("sub_borrow", 1, 16'hFFFE, 16'h0005, 16'h0003, 3'd0, 5'b0, 32'h15, 2'b00, 0, 16'h0006, 0);

        next_cycle(); drive(4'h8, 3'd1, 16'h0, 3'd0, 16'h8001, 16'h0001, 5'b0, 32'h16);
        expect_v("shl1", 1, 16'h0002, 16'h0, 16'h8001, 3'd0, 5'b0, 32'h16, 2'b00, 0, 16'h0004, 0);

        next_cycle(); drive(4'h9, 3'd1, 16'h0, 3'd0, 16'h0004, 16'h0003, 5'b0, 32'h17);
        expect_v("shr3", 1, 16'h0000, 16'h0, 16'h0004, 3'd0, 5'b0, 32'h17, 2'b00, 0, 16'h0005, 0);

        next_cycle(); drive(4'h8, 3'd1, 16'h0, 3'd0, 16'h8000, 16'h0000, 5'b0, 32'h18);
        expect_v("shl0_keep_c", 1, 16'h8000, 16'h0, 16'h8000, 3'd0, 5'b0, 32'h18, 2'b00, 0, 16'h0006, 0);

        next_cycle(); drive(4'h3, 3'd1, 16'h0, 3'd0, 16'h0000, 16'h0, 5'b0, 32'h19);
        expect_v("dec_zero", 1, 16'hFFFF, 16'h0, 16'h0000, 3'd0, 5'b0, 32'h19, 2'b00, 0, 16'h0006, 0);

        next_cycle(); drive(4'h6, 3'd1, 16'h0F0F, 3'd0, 16'h00F0, 16'h0, 5'b0, 32'h1A);
        expect_v("and_zero", 1, 16'h0000, 16'h0F0F, 16'h00F0, 3'd0, 5'b0, 32'h1A, 2'b00, 0, 16'h0005, 0);

        next_cycle(); drive(4'hB, 3'd1, 16'h0, 3'd0, 16'h1234, 16'h0, 5'b0, 32'h1B);
        expect_v("clrc", 1, 16'h1234, 16'h0, 16'h1234, 3'd0, 5'b0, 32'h1B, 2'b00, 0, 16'h0001, 0);

        next_cycle(); drive(4'hD, 3'd1, 16'h0, 3'd4, 16'h0000, 16'hBEEF, C_WB, 32'h1C);
        expect_v("ldm", 1, 16'hBEEF, 16'h0, 16'h0, 3'd4, C_WB, 32'h1C, 2'b00, 0, 16'h0001, 0);

        for (int i = 0; i < 2; i++) begin
            next_cycle(); stall = 1;
            drive(4'h4, 3'd4, 16'h0001, 3'd4, 16'h0001, 16'h0, C_MW, 32'h30 + i);
            expect_v("stall_hold", 1, 16'hBEEF, 16'h0, 16'h0, 3'd4, C_WB, 32'h1C, 2'b00, 0, 16'h0001, 0);
        end

        next_cycle(); flush = 1;
        drive(4'hA, 3'd6, 16'h0055, 3'd5, 16'h00AA, 16'h0, C_WB | C_MW | C_PU, 32'h31);
        expect_v("flush_setc", 1, 16'h00AA, 16'h0055, 16'h00AA, 3'd5, 5'b0, 32'h31, 2'b00, 0, 16'h0001, 0);

        next_cycle(); stall = 1; flush = 1;
        drive(4'h4, 3'd1, 16'h0001, 3'd1, 16'h0001, 16'h0, C_WB, 32'h33);
        expect_v("stall_over_flush", 1, 16'h00AA, 16'h0055, 16'h00AA, 3'd5, 5'b0, 32'h31, 2'b00, 0, 16'h0001, 0);

        next_cycle(); drive(4'hA, 3'd6, 16'h0002, 3'd5, 16'h0001, 16'h0, 5'b0, 32'h32);
        expect_v("setc", 1, 16'h0001, 16'h0002, 16'h0001, 3'd5, 5'b0, 32'h32, 2'b00, 0, 16'h0005, 0);

        next_cycle(); int_req = 1;
        drive(4'h1, 3'd2, 16'h0003, 3'd1, 16'h00FF, 16'h0, C_WB, 32'h0000_1233);
        expect_v("int_accept_not", 1, 16'hFF00, 16'h0003, 16'h00FF, 3'd1, C_WB, 32'h0000_1233, 2'b00, 0, 16'h0006, 1);

        next_cycle(); int_req = 1; stall = 1;
        drive(4'h4, 3'd1, 16'h0005, 3'd2, 16'h0005, 16'h0, C_WB | C_PO, 32'h2000);
        expect_v("slot_pc_hi", 0, 16'h0, 16'h0, 16'h0, 3'd0, C_SLOT, 32'h0000_1234, 2'b01, 1, 16'h0006, 1);

        next_cycle(); int_req = 1; flush = 1;
        drive(4'h4, 3'd1, 16'h0005, 3'd2, 16'h0005, 16'h0, C_WB, 32'h2001);
        expect_v("slot_pc_lo", 0, 16'h0, 16'h0, 16'h0, 3'd0, C_SLOT, 32'h0000_1234, 2'b10, 1, 16'h0006, 1);

        next_cycle(); int_req = 1;
        drive(4'h4, 3'd1, 16'h0005, 3'd2, 16'h0005, 16'h0, C_WB, 32'h2002);
        expect_v("slot_flags", 0, 16'h0, 16'h0, 16'h0, 3'd0, C_SLOT, 32'h0000_1234, 2'b11, 1, 16'h0006, 0);

        next_cycle(); drive(4'h2, 3'd1, 16'h0, 3'd0, 16'hFFFF, 16'h0, 5'b0, 32'h40);
        expect_v("inc_after_int", 1, 16'h0000, 16'h0, 16'hFFFF, 3'd0, 5'b0, 32'h40, 2'b00, 0, 16'h0005, 0);

        next_cycle(); int_req = 1;
        drive(4'hC, 3'd2, 16'h1357, 3'd3, 16'h0000, 16'h0, C_WB, 32'h50);
        expect_v("mov_int2", 1, 16'h1357, 16'h1357, 16'h0000, 3'd3, C_WB, 32'h50, 2'b00, 0, 16'h0005, 1);

        next_cycle(); drive(4'h0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0, 5'b0, 32'h60);
        expect_v("slot2_pc_hi", 0, 16'h0, 16'h0, 16'h0, 3'd0, C_SLOT, 32'h51, 2'b01, 1, 16'h0005, 1);

        next_cycle(); rst = 1;
        drive(4'h0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0, 5'b0, 32'h60);
        expect_v("rst_mid_int", 1, 16'h0, 16'h0, 16'h0, 3'd0, 5'b0, 32'h0, 2'b00, 0, 16'h0000, 0);

        next_cycle(); drive(4'h0, 3'd1, 16'h0, 3'd2, 16'h0042, 16'h0, 5'b0, 32'h60);
        expect_v("nop_after_rst", 1, 16'h0042, 16'h0, 16'h0042, 3'd2, 5'b0, 32'h60, 2'b00, 0, 16'h0000, 0);

        next_cycle();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d expected entries never compared, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
